// File: rtl/cr16_alu.sv
// CR16 16-bit ALU: combinational result/flag generation from A, B and opcode,
// captured into enable-gated output registers for write-back and PSR update.
module cr16_alu #(
  parameter int WIDTH = 16
) (
  input  logic             I_CLK,
  input  logic             I_NRESET,
  input  logic             I_ENABLE,
  input  logic [WIDTH-1:0] I_A,
  input  logic [WIDTH-1:0] I_B,
  input  logic [3:0]       I_OPCODE,
  output logic [WIDTH-1:0] O_C,
  output logic [4:0]       O_STATUS
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_ADDU  = 4'd1,
    OP_ADDC  = 4'd2,
    OP_ADDCU = 4'd3,
    OP_SUB   = 4'd4,
    OP_SUBU  = 4'd5,
    OP_AND   = 4'd6,
    OP_OR    = 4'd7,
    OP_XOR   = 4'd8,
    OP_NOT   = 4'd9,
    OP_LSH   = 4'd10,
    OP_RSH   = 4'd11,
    OP_ALSH  = 4'd12,
    OP_ARSH  = 4'd13
  } opcode_e;

  opcode_e          op;
  logic             carry_in;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             add_ovf;
  logic             sub_ovf;
  logic             sub_lt;
  logic             big_shift;
  logic [WIDTH-1:0] arsh_val;

  logic [WIDTH-1:0] r;
  logic             flag_c;
  logic             flag_l;
  logic             flag_f;
  logic             flag_z;
  logic             flag_n;

  assign op       = opcode_e'(I_OPCODE);
  assign carry_in = (op == OP_ADDC) || (op == OP_ADDCU);

  // One shared adder and one shared subtractor; the extra top bit is carry/borrow.
  assign sum  = {1'b0, I_A} + {1'b0, I_B} + {{WIDTH{1'b0}}, carry_in};
  assign diff = {1'b0, I_B} - {1'b0, I_A};

  assign add_ovf = (I_A[MSB] == I_B[MSB]) && (sum[MSB] != I_A[MSB]);
  assign sub_ovf = (I_A[MSB] != I_B[MSB]) && (diff[MSB] != I_B[MSB]);
  assign sub_lt  = $signed(I_B) < $signed(I_A);

  // The shift amount is the full 16-bit B, so large amounts must saturate explicitly.
  assign big_shift = I_B >= 16'(WIDTH);
  assign arsh_val  = big_shift ? {WIDTH{I_A[MSB]}} : WIDTH'($signed(I_A) >>> I_B);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    r      = '0;
    flag_c = 1'b0;
    flag_l = 1'b0;
    flag_f = 1'b0;
    flag_n = 1'b0;
    case (op)
      OP_ADD, OP_ADDC: begin
        r      = sum[MSB:0];
        flag_f = add_ovf;
        flag_n = sum[MSB];
      end
      OP_ADDU, OP_ADDCU: begin
        r      = sum[MSB:0];
        flag_c = sum[WIDTH];
      end
      OP_SUB: begin
        r      = diff[MSB:0];
        flag_f = sub_ovf;
        flag_n = sub_lt;
      end
      OP_SUBU: begin
        r      = diff[MSB:0];
        flag_c = diff[WIDTH];
        flag_l = diff[WIDTH];
      end
      OP_AND:           r = I_A & I_B;
      OP_OR:            r = I_A | I_B;
      OP_XOR:           r = I_A ^ I_B;
      OP_NOT:           r = ~I_A;
      OP_LSH, OP_ALSH:  r = big_shift ? '0 : (I_A << I_B);
      OP_RSH:           r = big_shift ? '0 : (I_A >> I_B);
      OP_ARSH:          r = arsh_val;
      default:          r = '0;
    endcase
    flag_z = (r == '0);
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    // NOTE: registered state uses non-blocking assignments so all flops update together.
    if (!I_NRESET) begin
      O_C      <= '0;
      O_STATUS <= '0;
    end else if (I_ENABLE) begin
      O_C      <= r;
      O_STATUS <= {flag_n, flag_z, flag_f, flag_l, flag_c};
    end
  end

endmodule

// File: tb/tb_cr16_alu.sv
// Self-checking bench for cr16_alu: randomized traffic compared every cycle against
// an integer-arithmetic reference, plus directed literal cases from the test plan.
module tb_cr16_alu;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  op;
  logic [15:0] dut_c;
  logic [4:0]  dut_s;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_c;
  logic [4:0]  exp_s;
  bit          cmp_on = 1'b0;

  cr16_alu #(.WIDTH(16)) dut (
    .I_CLK    (clk),
    .I_NRESET (rst_n),
    .I_ENABLE (en),
    .I_A      (a),
    .I_B      (b),
    .I_OPCODE (op),
    .O_C      (dut_c),
    .O_STATUS (dut_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  // Reference: plain integer arithmetic; returns {result, status{N,Z,F,L,C}}.
  function automatic logic [20:0] ref_alu(input logic [15:0] ia, input logic [15:0] ib,
                                          input logic [3:0] iop);
    int ua, ub, sa, sb, t;
    logic [15:0] res;
    bit c, l, f, n;
    ua = int'(ia);
    ub = int'(ib);
    sa = int'($signed(ia));
    sb = int'($signed(ib));
    res = 16'h0; c = 0; l = 0; f = 0; n = 0;
    case (iop)
      4'd0, 4'd2: begin
        t = sa + sb + ((iop == 4'd2) ? 1 : 0);
        res = 16'(t);
        f = (t > 32767) || (t < -32768);
        n = res[15];
      end
      4'd1, 4'd3: begin
        t = ua + ub + ((iop == 4'd3) ? 1 : 0);
        res = 16'(t);
        c = t > 65535;
      end
      4'd4: begin
        t = sb - sa;
        res = 16'(t);
        f = (t > 32767) || (t < -32768);
        n = sb < sa;
      end
      4'd5: begin
        res = 16'(ub - ua);
        c = ub < ua;
        l = ub < ua;
      end
      4'd6: res = ia & ib;
      4'd7: res = ia | ib;
      4'd8: res = ia ^ ib;
      4'd9: res = ~ia;
      4'd10, 4'd12: res = (ub >= 16) ? 16'h0 : 16'((ua * (1 << ub)) % 65536);
      4'd11: res = (ub >= 16) ? 16'h0 : 16'(ua / (1 << ub));
      4'd13: begin
        if (ub >= 16) res = ia[15] ? 16'hFFFF : 16'h0000;
        else          res = 16'(sa >>> ub);
      end
      default: res = 16'h0;
    endcase
    return {res, n, (res == 16'h0), f, l, c};
  endfunction

  // Expected register contents follow the documented load/hold/reset rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_c <= 16'h0;
      exp_s <= 5'h0;
    end else if (en) begin
      {exp_c, exp_s} <= ref_alu(a, b, op);
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("cycle_result", 32'(dut_c), 32'(exp_c));
      check("cycle_status", 32'(dut_s), 32'(exp_s));
    end
  end

  // Drive inputs just after an edge, then let one edge load them.
  task automatic step(input logic [15:0] ia, input logic [15:0] ib, input logic [3:0] iop,
                      input logic ien);
    @(posedge clk);
    #1;
    a = ia; b = ib; op = iop; en = ien;
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string name, input logic [15:0] ia, input logic [15:0] ib,
                          input logic [3:0] iop, input logic [15:0] rc, input logic [4:0] rs);
    step(ia, ib, iop, 1'b1);
    check({name, "_c"}, 32'(dut_c), 32'(rc));
    check({name, "_s"}, 32'(dut_s), 32'(rs));
    check({name, "_model"}, 32'(ref_alu(ia, ib, iop)), 32'({rc, rs}));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; a = 16'h1234; b = 16'h1111; op = 4'd0;
    #12;
    check("reset_c", 32'(dut_c), 32'h0);
    check("reset_s", 32'(dut_s), 32'h0);
    @(posedge clk);
    #1;
    check("reset_hold_c", 32'(dut_c), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release_c", 32'(dut_c), 32'h2345);
    cmp_on = 1'b1;

    directed("add_ovf", 16'h7FFF, 16'h0001, 4'd0,  16'h8000, 5'b10100);
    directed("addc",    16'hFFFF, 16'h0000, 4'd2,  16'h0000, 5'b01000);
    directed("addu",    16'hFC00, 16'h0400, 4'd1,  16'h0000, 5'b01001);
    directed("addcu",   16'hFFFF, 16'hFFFF, 4'd3,  16'hFFFF, 5'b00001);
    directed("sub",     16'h0400, 16'h0000, 4'd4,  16'hFC00, 5'b10000);
    directed("subu",    16'h0400, 16'h0000, 4'd5,  16'hFC00, 5'b00011);
    directed("sub_ovf", 16'h0001, 16'h8000, 4'd4,  16'h7FFF, 5'b10100);
    directed("and",     16'hF0F0, 16'h0FF0, 4'd6,  16'h00F0, 5'b00000);
    directed("xor",     16'hF0F0, 16'h0FF0, 4'd8,  16'hFF00, 5'b00000);
    directed("not",     16'h0000, 16'h1234, 4'd9,  16'hFFFF, 5'b00000);
    directed("rsh",     16'h8000, 16'h0004, 4'd11, 16'h0800, 5'b00000);
    directed("arsh",    16'h8000, 16'h0004, 4'd13, 16'hF800, 5'b00000);
    directed("lsh_big", 16'h8000, 16'h0400, 4'd10, 16'h0000, 5'b01000);
    directed("arsh_big",16'h8001, 16'h0010, 4'd13, 16'hFFFF, 5'b00000);
    directed("op14",    16'h1234, 16'h5678, 4'd14, 16'h0000, 5'b01000);

    // Enable hold: outputs must not move while disabled.
    directed("hold_load", 16'h0001, 16'h0002, 4'd0, 16'h0003, 5'b00000);
    step(16'h0005, 16'h0002, 4'd0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("hold_c", 32'(dut_c), 32'h0003);
    en = 1'b1;
    @(posedge clk); #1;
    check("reenable_c", 32'(dut_c), 32'h0007);

    // Randomized traffic with biased shift amounts and corner operands.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] ra, rb;
      logic [3:0]  rop;
      @(posedge clk);
      #1;
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rop = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 7))
        0: ra = 16'h8000;
        1: ra = 16'h7FFF;
        2: rb = 16'($urandom_range(0, 20));
        3: rb = ra;
        4: rb = 16'hFFFF;
        default: ;
      endcase
      a = ra; b = rb; op = rop;
      en = ($urandom_range(0, 9) != 0);
      if (i == 300) begin
        #2 rst_n = 1'b0;
        #1 check("async_reset_c", 32'(dut_c), 32'h0);
        check("async_reset_s", 32'(dut_s), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cmp_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cr16_alu.md
Name: cr16_alu

Overview:
- 16-bit arithmetic/logic unit for the CR16 datapath.
- Takes two operands and a 4-bit opcode and produces a 16-bit result plus a 5-bit condition/status vector.
- Result and status are registered on the clock, with an enable. The block feeds the register-file write-back path and the PSR flag logic.

Parameters:
- WIDTH, 16, operand/result width; all behaviour below is specified for 16.

Ports:
- I_CLK  input  1  system clock; all state changes on the rising edge.
- I_NRESET  input  1  asynchronous, active-low reset.
- I_ENABLE  input  1  when 1, result and status registers load on the rising edge; when 0 they hold.
- I_A  input  16  operand A (subtrahend for SUB/SUBU; shifted value for shifts).
- I_B  input  16  operand B (minuend for SUB/SUBU; shift amount for shifts).
- I_OPCODE  input  4  operation select.
- O_C  output  16  registered result.
- O_STATUS  output  5  registered flags: [0] C carry/borrow, [1] L low, [2] F signed overflow, [3] Z zero, [4] N negative.

Behaviour:
- One clock, asynchronous active-low reset.
- Reset (I_NRESET=0, asynchronous): O_C=0x0000, O_STATUS=5'b00000 immediately; held while low.
- Latency:
  - Next result R and flags S are computed combinationally from I_A, I_B, I_OPCODE.
  - On the rising edge with I_ENABLE=1: O_C<=R, O_STATUS<=S.
  - Outputs are valid one clock after inputs are stable.
  - I_ENABLE=0: outputs hold.
- Arithmetic is modulo 2^16. "Signed" means two's complement.
- Z=1 iff R==0 for every opcode. Any flag not listed for an opcode is 0.
- Opcode 0, ADD:
  - R=A+B.
  - F=1 on signed overflow (A[15]==B[15] and R[15]!=A[15]).
  - N=R[15].
  - C=0, L=0.
- Opcode 1, ADDU:
  - R=A+B.
  - C=carry out of bit 15.
  - N=0, F=0, L=0.
- Opcode 2, ADDC: R=A+B+1 (carry-in fixed at 1). F and N as for ADD, computed on the full A+B+1. C=0.
- Opcode 3, ADDCU: R=A+B+1. C=carry out of the 17-bit sum. N=0, F=0.
- Opcode 4, SUB:
  - R=B-A.
  - F=1 iff A[15]!=B[15] and R[15]!=B[15].
  - N=1 iff signed(B)<signed(A).
  - C=0, L=0.
- Opcode 5, SUBU:
  - R=B-A.
  - C=1 iff unsigned B<A (borrow).
  - L=1 iff unsigned B<A.
  - N=0, F=0.
- Opcode 6, AND: R=A&B.
- Opcode 7, OR: R=A|B.
- Opcode 8, XOR: R=A^B.
- Opcode 9, NOT: R=~A; I_B is ignored.
- Opcode 10, LSH: R=A<<B, logical. B is a full 16-bit unsigned amount; any amount >=16 gives 0.
- Opcode 11, RSH: R=A>>B, logical, zero-fill; amount >=16 gives 0.
- Opcode 12, ALSH: R=A<<B, identical to LSH.
- Opcode 13, ARSH:
  - R=A arithmetically shifted right by B, filling with A[15].
  - Amount >=16 gives 0xFFFF if A[15]=1, else 0x0000.
- Opcodes 14, 15: R=0, S=5'b01000 (Z only).
- Overflow/carry wrap: the 16-bit result always wraps. Flags report the wrap; they never saturate.
- Reset asserted mid-operation overrides enable; the first load after reset release occurs on the first rising edge with I_NRESET=1 and I_ENABLE=1.

Test Plan:
- Reset: I_NRESET=0 with A=0x1234, B=0x1111, ADD, enable=1 -> O_C=0x0000, O_STATUS=00000. Release reset and clock once -> O_C=0x2345.
- ADD overflow: A=0x7FFF, B=0x0001, op 0 -> O_C=0x8000, O_STATUS=10100. ADDC: A=0xFFFF, B=0x0000, op 2 -> O_C=0x0000, O_STATUS=01000.
- ADDU carry: A=0xFC00, B=0x0400, op 1 -> O_C=0x0000, O_STATUS=01001. ADDCU: A=0xFFFF, B=0xFFFF, op 3 -> O_C=0xFFFF, O_STATUS=00001.
- SUB/SUBU:
  - A=0x0400, B=0x0000, op 4 -> O_C=0xFC00, O_STATUS=10000.
  - Same operands, op 5 -> O_C=0xFC00, O_STATUS=00011.
  - A=0x0001, B=0x8000, op 4 -> O_C=0x7FFF, O_STATUS=10100.
- Logic/shift:
  - A=0xF0F0, B=0x0FF0: op 6 -> 0x00F0; op 8 -> 0xFF00.
  - op 9 with A=0x0000 -> 0xFFFF.
  - A=0x8000, B=4: op 11 -> 0x0800; op 13 -> 0xF800.
  - B=0x0400, op 10 -> 0x0000, O_STATUS=01000.
- Enable hold: load ADD 1+2 (O_C=3), then set I_ENABLE=0, change A=5 and clock 3 times -> O_C stays 0x0003. Re-enable -> 0x0007 after one edge.
